// File: rtl/secded_stream_decoder.sv
// SECDED stream decoder: corrects single-bit errors, flags or drops uncorrectable beats, keeps per-channel counters.
// Latency 2 cycles at 1 beat/cycle; in_tready_o follows out_tready_i combinationally through both stages.
module secded_stream_decoder #(
    parameter int DATA_WIDTH         = 32,
    parameter int N_CHANNELS         = 4,
    parameter int COUNTER_WIDTH      = 16,
    parameter int DEST_WIDTH         = 4,
    parameter bit DROP_UNCORRECTABLE = 1'b0,
    localparam int P                 = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1),
    localparam int CW_WIDTH          = DATA_WIDTH + P + 1
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic [CW_WIDTH-1:0]                 in_tdata_i,
    input  logic                                in_tvalid_i,
    output logic                                in_tready_o,
    input  logic [DEST_WIDTH-1:0]               in_tdest_i,
    input  logic                                in_tlast_i,
    output logic [DATA_WIDTH-1:0]               out_tdata_o,
    output logic                                out_tvalid_o,
    input  logic                                out_tready_i,
    output logic [DEST_WIDTH-1:0]               out_tdest_o,
    output logic                                out_tlast_o,
    output logic [1:0]                          out_tuser_o,
    input  logic                                clear_counters_i,
    output logic [N_CHANNELS*COUNTER_WIDTH-1:0] corrected_count_o,
    output logic [N_CHANNELS*COUNTER_WIDTH-1:0] uncorrectable_count_o
);

    // One extra bit so a codeword length of exactly 2^P still compares correctly.
    localparam logic [P:0] CW_LIMIT = (P+1)'(CW_WIDTH);

    logic [1:0]               rdy_en_q;
    logic                     s1_vld_q, s1_last_q, s1_par_q;
    logic [CW_WIDTH-1:0]      s1_cw_q;
    logic [DEST_WIDTH-1:0]    s1_dest_q;
    logic [P-1:0]             s1_syn_q;
    logic                     s2_vld_q, s2_last_q;
    logic [DATA_WIDTH-1:0]    s2_data_q;
    logic [DEST_WIDTH-1:0]    s2_dest_q;
    logic [1:0]               s2_user_q;
    logic [COUNTER_WIDTH-1:0] corr_cnt_q [N_CHANNELS];
    logic [COUNTER_WIDTH-1:0] unc_cnt_q  [N_CHANNELS];

    logic [P-1:0]             syn_d;
    logic                     par_d;
    logic [CW_WIDTH-1:0]      fixed_cw;
    logic [DATA_WIDTH-1:0]    data_d;
    logic                     s1_corr, s1_unc, s1_drop, s1_move, s1_adv, s2_adv, in_fire;

    // Release is seen by the ready path only after two edges, so tready never rises on the release edge.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) rdy_en_q <= '0;
        else         rdy_en_q <= {rdy_en_q[0], 1'b1};
    end

    always_comb begin
        syn_d = '0;
        for (int i = 1; i < CW_WIDTH; i++)
            if (in_tdata_i[i]) syn_d = syn_d ^ P'(i);
    end
    assign par_d = ^in_tdata_i;

    assign s1_corr = s1_par_q && ({1'b0, s1_syn_q} < CW_LIMIT);
    assign s1_unc  = (s1_par_q && !({1'b0, s1_syn_q} < CW_LIMIT)) || (!s1_par_q && (s1_syn_q != '0));

    always_comb begin
        int j;
        fixed_cw = s1_cw_q ^ ({{(CW_WIDTH-1){1'b0}}, s1_corr} << s1_syn_q);
        data_d   = '0;
        j        = 0;
        for (int i = 1; i < CW_WIDTH; i++) begin
            if ((i & (i - 1)) != 0) begin
                data_d[j] = fixed_cw[i];
                j++;
            end
        end
    end

    assign s1_drop     = DROP_UNCORRECTABLE && s1_vld_q && s1_unc;
    assign s2_adv      = !s2_vld_q || out_tready_i;
    assign s1_move     = s1_vld_q && (s2_adv || s1_drop);
    assign s1_adv      = !s1_vld_q || s1_move;
    assign in_tready_o = rdy_en_q[1] && s1_adv;
    assign in_fire     = in_tvalid_i && in_tready_o;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            s1_vld_q  <= 1'b0;
            s1_cw_q   <= '0;
            s1_dest_q <= '0;
            s1_last_q <= 1'b0;
            s1_syn_q  <= '0;
            s1_par_q  <= 1'b0;
        end else if (s1_adv) begin
            s1_vld_q <= in_fire;
            if (in_fire) begin
                s1_cw_q   <= in_tdata_i;
                s1_dest_q <= in_tdest_i;
                s1_last_q <= in_tlast_i;
                s1_syn_q  <= syn_d;
                s1_par_q  <= par_d;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_dest_q <= '0;
            s2_last_q <= 1'b0;
            s2_user_q <= '0;
        end else if (s2_adv) begin
            s2_vld_q <= s1_vld_q && !s1_drop;
            if (s1_vld_q && !s1_drop) begin
                s2_data_q <= data_d;
                s2_dest_q <= s1_dest_q;
                s2_last_q <= s1_last_q;
                s2_user_q <= {s1_unc, s1_corr};
            end
        end
    end

    // A clear wins over an increment on the same edge; out-of-range tdest is never counted.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                corr_cnt_q[k] <= '0;
                unc_cnt_q[k]  <= '0;
            end
        end else if (clear_counters_i) begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                corr_cnt_q[k] <= '0;
                unc_cnt_q[k]  <= '0;
            end
        end else if (s1_move) begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                if (32'(s1_dest_q) == k) begin
                    if (s1_corr && (corr_cnt_q[k] != '1)) corr_cnt_q[k] <= corr_cnt_q[k] + 1'b1;
                    if (s1_unc && (unc_cnt_q[k] != '1))   unc_cnt_q[k]  <= unc_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < N_CHANNELS; k++) begin : g_cnt_out
        assign corrected_count_o[k*COUNTER_WIDTH +: COUNTER_WIDTH]     = corr_cnt_q[k];
        assign uncorrectable_count_o[k*COUNTER_WIDTH +: COUNTER_WIDTH] = unc_cnt_q[k];
    end

    assign out_tvalid_o = s2_vld_q;
    assign out_tdata_o  = s2_data_q;
    assign out_tdest_o  = s2_dest_q;
    assign out_tlast_o  = s2_last_q;
    assign out_tuser_o  = s2_user_q;

endmodule
